// File: rtl/mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
// FSM states, Booth operation codes and iteration count helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } booth_op_t;

    function automatic int iter_of(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder.
// Maps {b[2i+1], b[2i], b[2i-1]} to a partial-product operation.
module booth_r4_enc
    import mul_pkg::*;
(
    input  logic [2:0] grp,
    output booth_op_t  op
);

    always_comb begin
        op = ZERO;
        unique case (1'b1)
            (grp == 3'b001) || (grp == 3'b010): op = PM;
            (grp == 3'b011):                    op = P2M;
            (grp == 3'b100):                    op = N2M;
            (grp == 3'b101) || (grp == 3'b110): op = NM;
            default:                            op = ZERO;
        endcase
    end

endmodule

// File: rtl/seq_booth_mul.sv
// Multi-cycle radix-4 Booth multiplier, signed or unsigned.
// One shared adder; start/busy/done handshake; HI/LO product.
module seq_booth_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITER = iter_of(WIDTH);
    localparam int EW   = WIDTH + 2;
    localparam int AW   = WIDTH + 4;
    localparam int CW   = $clog2(ITER + 1);

    state_t            state_q;
    state_t            state_nx;
    logic [EW-1:0]     m_q;
    logic [EW-1:0]     mq_q;
    logic              q1_q;
    logic [AW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;

    booth_op_t         op;
    logic [AW-1:0]     m_ext;
    logic [AW-1:0]     addend;
    logic [AW-1:0]     sum;
    logic [AW-1:0]     acc_nx;
    logic [EW-1:0]     mq_nx;
    logic [2*WIDTH-1:0] prod;
    logic              last;
    logic              accept;

    booth_r4_enc u_enc (
        .grp ({mq_q[1:0], q1_q}),
        .op  (op)
    );

    assign m_ext  = {{2{m_q[EW-1]}}, m_q};
    assign last   = (cnt_q == CW'(ITER - 1));
    assign accept = start && (state_q != RUN);

    always_comb begin
        addend = '0;
        case (op)
            PM:      addend = m_ext;
            P2M:     addend = m_ext << 1;
            NM:      addend = -m_ext;
            N2M:     addend = -(m_ext << 1);
            default: addend = '0;
        endcase
    end

    // Add, then arithmetic shift the {acc, multiplier} pair by two.
    assign sum    = acc_q + addend;
    assign acc_nx = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign mq_nx  = {sum[1:0], mq_q[EW-1:2]};
    assign prod   = {acc_nx[WIDTH-3:0], mq_nx};

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            mq_q  <= '0;
            q1_q  <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (accept) begin
            m_q   <= signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            mq_q  <= signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
            q1_q  <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            acc_q <= acc_nx;
            mq_q  <= mq_nx;
            q1_q  <= mq_q[1];
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                hi_q <= prod[2*WIDTH-1:WIDTH];
                lo_q <= prod[WIDTH-1:0];
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_seq_booth_mul.sv
// Self-checking bench for seq_booth_mul (WIDTH=32).
// Reference product is plain 64-bit arithmetic on the operands.
module tb_seq_booth_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int LAT = 18;
    localparam int BOUND = 60;

    always #5 clk = ~clk;

    seq_booth_mul #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    function automatic logic [63:0] ref_mul(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic        sm
    );
        longint sx;
        longint sy;
        logic [63:0] ux;
        logic [63:0] uy;
        if (sm) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'h0, x};
        uy = {32'h0, y};
        return ux * uy;
    endfunction

    // Launch one operation and wait (bounded) for done.
    task automatic do_mul(
        input  logic [31:0] x,
        input  logic [31:0] y,
        input  logic        sm,
        output int          lat,
        output logic        got,
        output logic [63:0] res
    );
        @(negedge clk);
        a = x;
        b = y;
        signed_mode = sm;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            a = $urandom;
            b = $urandom;
            signed_mode = $urandom_range(0, 1);
            lat++;
        end while (!done && lat < BOUND);
        got = done;
        res = {hi, lo};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0 0",
                     busy, done);
        end
        n_cmp++;
        if ({hi, lo} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_hilo: got %h_%h want 0", hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vm [8];
        int          lat;
        logic        got;
        logic [63:0] res;
        logic [63:0] exp;
        va = '{32'h1F9, 32'h8B, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h80000000, 32'h80000000, 32'h0, 32'h7FFFFFFF};
        vb = '{32'hF0, 32'hFFFFFF74, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            do_mul(va[i], vb[i], vm[i], lat, got, res);
            exp = ref_mul(va[i], vb[i], vm[i]);
            n_cmp++;
            if (!got || res !== exp) begin
                n_bad++;
                $display("FAIL directed_%0d: got %h done=%b want %h",
                         i, res, got, exp);
            end
            if (i == 0) begin
                n_cmp++;
                if (lat !== LAT) begin
                    n_bad++;
                    $display("FAIL latency: got %0d want %0d", lat, LAT);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [5];
        logic [31:0] x;
        logic [31:0] y;
        logic        sm;
        int          lat;
        logic        got;
        logic [63:0] res;
        logic [63:0] exp;
        corner = '{32'h0, 32'hFFFFFFFF, 32'h80000000,
                   32'h7FFFFFFF, 32'h1};
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) x = corner[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) y = corner[$urandom_range(0, 4)];
            sm = $urandom_range(0, 1);
            do_mul(x, y, sm, lat, got, res);
            exp = ref_mul(x, y, sm);
            n_cmp++;
            if (!got || lat !== LAT || res !== exp) begin
                n_bad++;
                $display("FAIL random_%0d: %h*%h sm=%b got %h lat=%0d want %h lat=%0d",
                         i, x, y, sm, res, lat, exp, LAT);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [63:0] h0;
        logic [63:0] exp;
        int          lat;
        int          n_done;
        logic        moved;
        h0 = {hi, lo};
        exp = ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b1);
        moved = 1'b0;
        n_done = 0;
        @(negedge clk);
        a = 32'h12345678;
        b = 32'h9ABCDEF0;
        signed_mode = 1'b1;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = (lat == 5);
            a = 32'h00000003;
            b = 32'h00000007;
            signed_mode = 1'b0;
            lat++;
            if (busy && {hi, lo} !== h0) moved = 1'b1;
        end while (!done && lat < BOUND);
        start = 1'b0;
        if (done) n_done++;
        n_cmp++;
        if (moved) begin
            n_bad++;
            $display("FAIL hold_during_run: hi/lo changed, want %h", h0);
        end
        n_cmp++;
        if ({hi, lo} !== exp || lat !== LAT) begin
            n_bad++;
            $display("FAIL ignore_start: got %h lat=%0d want %h lat=%0d",
                     {hi, lo}, lat, exp, LAT);
        end
        repeat (6) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_cmp++;
        if (n_done !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got %0d dones busy=%b want 1 busy=0",
                     n_done, busy);
        end
        n_cmp++;
        if ({hi, lo} !== exp) begin
            n_bad++;
            $display("FAIL hold_idle: got %h want %h", {hi, lo}, exp);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic        got;
        logic [63:0] res;
        logic [63:0] exp1;
        logic [63:0] exp2;
        exp1 = ref_mul(32'hDEADBEEF, 32'h00C0FFEE, 1'b1);
        exp2 = ref_mul(32'hFEDCBA98, 32'h87654321, 1'b0);
        do_mul(32'hDEADBEEF, 32'h00C0FFEE, 1'b1, lat, got, res);
        n_cmp++;
        if (!got || res !== exp1) begin
            n_bad++;
            $display("FAIL b2b_first: got %h want %h", res, exp1);
        end
        a = 32'hFEDCBA98;
        b = 32'h87654321;
        signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_busy: got busy=%b done=%b want 1 0",
                     busy, done);
        end
        lat = 1;
        while (!done && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (!done || lat !== LAT || {hi, lo} !== exp2) begin
            n_bad++;
            $display("FAIL b2b_second: got %h lat=%0d want %h lat=%0d",
                     {hi, lo}, lat, exp2, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        int          n_done;
        logic        got;
        logic [63:0] res;
        logic [63:0] exp;
        @(negedge clk);
        a = 32'h55555555;
        b = 32'hAAAAAAAA;
        signed_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00 || {hi, lo} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b done=%b %h want 0",
                     busy, done, {hi, lo});
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_bad++;
            $display("FAIL abort: got %0d active cycles want 0", n_done);
        end
        do_mul(32'd3, 32'd5, 1'b0, lat, got, res);
        exp = ref_mul(32'd3, 32'd5, 1'b0);
        n_cmp++;
        if (!got || res !== exp) begin
            n_bad++;
            $display("FAIL after_reset: got %h want %h", res, exp);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
